// File: rtl/rr_arb_spill.sv
// rr_arb_spill: N-input to 1-output stream merger.
//
// Each input stream passes through a two-entry spill register (slot A is
// presented to the arbiter, slot B absorbs one extra beat). Because in_ready_o
// comes only from registered state, no combinational path runs from any input
// port to the output port. A round-robin arbiter with lock-in merges the slot-A
// heads onto a single valid/ready output.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   in_valid_i   per-input valid                 [NUM_IN]
//   in_ready_o   per-input ready                 [NUM_IN]
//   in_data_i    per-input payload               [NUM_IN][DATA_WIDTH]
//   out_valid_o  merged output valid
//   out_ready_i  consumer ready
//   out_data_o   granted payload (0 when not valid)
//   out_idx_o    granted input index (0 when not valid)
module rr_arb_spill #(
    parameter  int NUM_IN     = 4,
    parameter  int DATA_WIDTH = 32,
    localparam int IDX_WIDTH  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NUM_IN-1:0]                  in_valid_i,
    output logic [NUM_IN-1:0]                  in_ready_o,
    input  logic [NUM_IN-1:0][DATA_WIDTH-1:0]  in_data_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [DATA_WIDTH-1:0]              out_data_o,
    output logic [IDX_WIDTH-1:0]               out_idx_o
);

    logic [NUM_IN-1:0]     a_full;
    logic [DATA_WIDTH-1:0] a_data [NUM_IN];
    logic [NUM_IN-1:0]     push;
    logic [NUM_IN-1:0]     drain;

    logic [IDX_WIDTH-1:0]  gnt_idx;
    logic                  hs;

    logic [IDX_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic                  lock_q, lock_d;
    logic [IDX_WIDTH-1:0]  lock_idx_q, lock_idx_d;

    // ------------------------------------------------------------------
    // Per-input spill registers
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_spill
            logic                  a_full_q, a_full_d;
            logic                  b_full_q, b_full_d;
            logic [DATA_WIDTH-1:0] a_data_q, a_data_d;
            logic [DATA_WIDTH-1:0] b_data_q, b_data_d;

            // Ready depends on slot B only, so a full A never blocks the
            // upstream for one beat and out_ready_i never reaches in_ready_o.
            assign in_ready_o[gi] = ~b_full_q & ~rst_i;
            assign push[gi]       = in_valid_i[gi] & in_ready_o[gi];
            assign drain[gi]      = hs & (gnt_idx == IDX_WIDTH'(gi));
            assign a_full[gi]     = a_full_q;
            assign a_data[gi]     = a_data_q;

            always_comb begin
                a_full_d = a_full_q;
                b_full_d = b_full_q;
                a_data_d = a_data_q;
                b_data_d = b_data_q;
                if (drain[gi] && b_full_q) begin
                    // Refill A from B; ready is low this cycle so no push.
                    a_data_d = b_data_q;
                    b_full_d = 1'b0;
                end else if (drain[gi]) begin
                    // A drains with B empty: an incoming beat lands in A.
                    a_full_d = push[gi];
                    if (push[gi]) begin
                        a_data_d = in_data_i[gi];
                    end
                end else if (push[gi]) begin
                    if (!a_full_q) begin
                        a_full_d = 1'b1;
                        a_data_d = in_data_i[gi];
                    end else begin
                        b_full_d = 1'b1;
                        b_data_d = in_data_i[gi];
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    a_full_q <= 1'b0;
                    b_full_q <= 1'b0;
                    a_data_q <= '0;
                    b_data_q <= '0;
                end else begin
                    a_full_q <= a_full_d;
                    b_full_q <= b_full_d;
                    a_data_q <= a_data_d;
                    b_data_q <= b_data_d;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin selection with lock-in
    // ------------------------------------------------------------------
    // Scan offsets from the highest down so the lowest offset from the
    // pointer that is requesting wins.
    always_comb begin
        int cand;
        cand    = 0;
        gnt_idx = '0;
        if (lock_q) begin
            gnt_idx = lock_idx_q;
        end else begin
            for (int off = NUM_IN - 1; off >= 0; off--) begin
                cand = int'(rr_ptr_q) + off;
                if (cand >= NUM_IN) begin
                    cand = cand - NUM_IN;
                end
                if (a_full[cand[IDX_WIDTH-1:0]]) begin
                    gnt_idx = cand[IDX_WIDTH-1:0];
                end
            end
        end
    end

    assign out_valid_o = (|a_full) & ~rst_i;
    assign out_data_o  = out_valid_o ? a_data[gnt_idx] : '0;
    assign out_idx_o   = out_valid_o ? gnt_idx : '0;
    assign hs          = out_valid_o & out_ready_i;

    // A stalled offer is pinned to its index so the output stays stable
    // until the consumer takes it.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (hs) begin
            lock_d   = 1'b0;
            rr_ptr_d = (gnt_idx == IDX_WIDTH'(NUM_IN - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (out_valid_o) begin
            lock_d     = 1'b1;
            lock_idx_d = gnt_idx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: tb/tb_rr_arb_spill.sv
// Directed bench for rr_arb_spill (NUM_IN=4, DATA_WIDTH=32). Accepted input
// beats are pushed into per-input expected queues; each output handshake pops
// the queue of the presented index and compares the payload.
module tb_rr_arb_spill;

    logic             clk;
    logic             rst;
    logic [3:0]       in_valid;
    logic [3:0]       in_ready;
    logic [3:0][31:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [1:0]       out_idx;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q [4][$];
    int          seq   [4];

    logic        hs_fire;
    logic [1:0]  hs_idx;

    rr_arb_spill #(
        .NUM_IN     (4),
        .DATA_WIDTH (32)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_idx_o   (out_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are set at the falling edge; this samples the handshakes just
    // after, runs through the rising edge and returns at the next falling edge.
    task automatic step();
        logic [31:0] exp_d;
        #1;
        hs_fire = 1'b0;
        if (rst) begin
            for (int i = 0; i < 4; i++) exp_q[i].delete();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (in_valid[i] && in_ready[i]) begin
                    exp_q[i].push_back(in_data[i]);
                    seq[i]++;
                end
            end
            if (out_valid && out_ready) begin
                hs_fire = 1'b1;
                hs_idx  = out_idx;
                chk("sb_avail", 32'(exp_q[out_idx].size() != 0), 32'd1);
                if (exp_q[out_idx].size() != 0) begin
                    exp_d = exp_q[out_idx].pop_front();
                    chk("sb_data", out_data, exp_d);
                end
                $display("hs idx=%0d data=%0h", out_idx, out_data);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int exp_idx;
        int served [4];
        int hs_cnt;
        logic consec_ok;
        int left;

        for (int i = 0; i < 4; i++) seq[i] = 0;
        hs_fire   = 1'b0;
        hs_idx    = '0;
        out_ready = 1'b0;
        in_valid  = 4'hF;
        for (int i = 0; i < 4; i++) in_data[i] = 32'(256 * i);

        // ---------------- Reset then idle ----------------
        rst = 1'b1;
        step();
        chk("rst_valid_c1", 32'(out_valid), 32'd0);
        chk("rst_ready_c1", 32'(in_ready), 32'h0);
        step();
        chk("rst_valid_c2", 32'(out_valid), 32'd0);
        chk("rst_ready_c2", 32'(in_ready), 32'h0);
        rst      = 1'b0;
        in_valid = 4'h0;
        step();
        chk("idle_ready", 32'(in_ready), 32'hF);
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_data", out_data, 32'd0);
        chk("idle_idx", 32'(out_idx), 32'd0);
        in_valid[0] = 1'b1;
        in_data[0]  = 32'h55;
        step();
        in_valid = 4'h0;
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_idx", 32'(out_idx), 32'd0);
        chk("lat_data", out_data, 32'h55);
        out_ready = 1'b1;
        step();
        chk("lat_hs", 32'(hs_fire), 32'd1);
        out_ready = 1'b0;

        // ---------------- Round robin ----------------
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seq[i] = 0;
            served[i] = 0;
        end
        exp_idx   = 0;
        out_ready = 1'b1;
        in_valid  = 4'hF;
        for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < 4; i++) in_data[i] = 32'(256 * i + seq[i]);
            step();
            if (hs_fire) begin
                chk("rr_idx", 32'(hs_idx), 32'(exp_idx));
                exp_idx = (exp_idx + 1) % 4;
                served[hs_idx]++;
            end
        end
        for (int i = 0; i < 4; i++) chk("rr_served", 32'(served[i] >= 5), 32'd1);
        in_valid = 4'h0;
        for (int k = 0; k < 12; k++) step();
        left = 0;
        for (int i = 0; i < 4; i++) left += exp_q[i].size();
        chk("rr_drained", 32'(left), 32'd0);
        chk("rr_idle_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // ---------------- Backpressure and lock-in ----------------
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid[2] = 1'b1;
        in_data[2]  = 32'hA5;
        step();
        in_valid = 4'h0;
        chk("lock_idx0", 32'(out_idx), 32'd2);
        chk("lock_data0", out_data, 32'hA5);
        in_valid[0] = 1'b1;
        in_data[0]  = 32'h11;
        step();
        in_valid = 4'h0;
        chk("lock_idx1", 32'(out_idx), 32'd2);
        chk("lock_data1", out_data, 32'hA5);
        step();
        chk("lock_idx2", 32'(out_idx), 32'd2);
        chk("lock_data2", out_data, 32'hA5);
        out_ready = 1'b1;
        step();
        chk("lock_hs_idx", 32'(hs_idx), 32'd2);
        chk("next_idx", 32'(out_idx), 32'd0);
        chk("next_data", out_data, 32'h11);
        step();
        chk("next_hs", 32'(hs_fire), 32'd1);
        out_ready = 1'b0;

        // ---------------- Spill fill ----------------
        in_valid[1] = 1'b1;
        in_data[1]  = 32'hB0;
        step();
        chk("spill_rdy_a", 32'(in_ready[1]), 32'd1);
        in_data[1] = 32'hB1;
        step();
        chk("spill_rdy_b", 32'(in_ready[1]), 32'd0);
        in_data[1] = 32'hB2;
        step();
        step();
        chk("spill_held_rdy", 32'(in_ready[1]), 32'd0);
        chk("spill_head", out_data, 32'hB0);
        chk("spill_count", 32'(exp_q[1].size()), 32'd2);
        out_ready = 1'b1;
        step();
        chk("spill_rdy_back", 32'(in_ready[1]), 32'd1);
        chk("spill_second", out_data, 32'hB1);
        step();
        in_valid = 4'h0;
        chk("spill_third", out_data, 32'hB2);
        step();
        chk("spill_empty", 32'(out_valid), 32'd0);

        // ---------------- Full throughput, single input ----------------
        hs_cnt    = 0;
        consec_ok = 1'b1;
        for (int k = 0; k < 11; k++) begin
            if (k < 10) begin
                in_valid[0] = 1'b1;
                in_data[0]  = 32'hC0 + 32'(k);
                chk("tp_ready", 32'(in_ready[0]), 32'd1);
            end else begin
                in_valid = 4'h0;
            end
            step();
            if (k == 0) chk("tp_first_idle", 32'(hs_fire), 32'd0);
            else if (!hs_fire) consec_ok = 1'b0;
            if (hs_fire) hs_cnt++;
        end
        chk("tp_count", 32'(hs_cnt), 32'd10);
        chk("tp_consec", 32'(consec_ok), 32'd1);
        out_ready = 1'b0;

        // ---------------- Reset mid-stream ----------------
        in_valid = 4'hF;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) in_data[i] = 32'hD00 + 32'(16 * i + k);
            step();
        end
        chk("mid_full", 32'(in_ready), 32'h0);
        rst = 1'b1;
        step();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'h0);
        rst      = 1'b0;
        in_valid = 4'h0;
        step();
        chk("post_ready", 32'(in_ready), 32'hF);
        chk("post_valid", 32'(out_valid), 32'd0);
        in_valid   = 4'b1001;
        in_data[0] = 32'hE0;
        in_data[3] = 32'hE3;
        step();
        in_valid = 4'h0;
        chk("post_ptr_idx", 32'(out_idx), 32'd0);
        chk("post_ptr_data", out_data, 32'hE0);
        out_ready = 1'b1;
        step();
        chk("post_hs0", 32'(hs_idx), 32'd0);
        step();
        chk("post_hs3", 32'(hs_idx), 32'd3);
        step();
        chk("post_idle", 32'(out_valid), 32'd0);
        chk("post_stale", 32'(hs_fire), 32'd0);
        left = 0;
        for (int i = 0; i < 4; i++) left += exp_q[i].size();
        chk("final_drained", 32'(left), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
